// File: rtl/sfx_pkg.sv
// Shared constants, channel state type and helper function for the sound-effect player.
package sfx_pkg;

  // Event-to-channel mapping used by the game logic.
  localparam int SFX_PADDLE = 0;
  localparam int SFX_BLOCK  = 1;
  localparam int SFX_WALL   = 2;
  localparam int SFX_LOST   = 3;

  // Default half-periods in 40 MHz cycles (tone = 40e6 / (2 * half-period)).
  localparam logic [15:0] SFX_PADDLE_HALF = 16'd45454; // ~440 Hz
  localparam logic [15:0] SFX_BLOCK_HALF  = 16'd22727; // ~880 Hz
  localparam logic [15:0] SFX_WALL_HALF   = 16'd30303; // ~660 Hz
  localparam logic [15:0] SFX_LOST_HALF   = 16'd60606; // ~330 Hz

  // Default durations in 1 kHz ticks (milliseconds).
  localparam logic [11:0] SFX_PADDLE_DUR = 12'd50;
  localparam logic [11:0] SFX_BLOCK_DUR  = 12'd30;
  localparam logic [11:0] SFX_WALL_DUR   = 12'd20;
  localparam logic [11:0] SFX_LOST_DUR   = 12'd500;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PLAY = 1'b1
  } ch_state_e;

  // Number of bits needed to index 'value' distinct states (ceil(log2(value))).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sfx_channel.sv
// One tone channel: IDLE/PLAY state, square-wave tone counter and tick-based duration counter.
module sfx_channel
  import sfx_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DUR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 trigger,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic [DUR_WIDTH-1:0] duration,
  output logic                 busy,
  output logic                 level
);

  ch_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] hp_q, hp_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DUR_WIDTH-1:0] rem_q, rem_d;
  logic                 level_q, level_d;

  // Next-state logic: a trigger always wins over expiry; a zero-length trigger stops a playing channel.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    level_d = level_q;
    case (state_q)
      CH_IDLE: begin
        level_d = 1'b0;
        if (trigger && (duration != {DUR_WIDTH{1'b0}})) begin
          state_d = CH_PLAY;
          hp_d    = half_period;
          rem_d   = duration;
          cnt_d   = {DIV_WIDTH{1'b0}};
        end else begin
          state_d = CH_IDLE;
        end
      end
      CH_PLAY: begin
        if (trigger) begin
          level_d = 1'b0;
          cnt_d   = {DIV_WIDTH{1'b0}};
          if (duration != {DUR_WIDTH{1'b0}}) begin
            state_d = CH_PLAY;
            hp_d    = half_period;
            rem_d   = duration;
          end else begin
            state_d = CH_IDLE;
          end
        end else if (tick && (rem_q == DUR_WIDTH'(1))) begin
          state_d = CH_IDLE;
          level_d = 1'b0;
        end else begin
          if (tick) begin
            rem_d = rem_q - DUR_WIDTH'(1);
          end else begin
            rem_d = rem_q;
          end
          // A zero half-period is a rest: silence while the duration runs.
          if (hp_q == {DIV_WIDTH{1'b0}}) begin
            level_d = 1'b0;
          end else if (cnt_q == (hp_q - DIV_WIDTH'(1))) begin
            cnt_d   = {DIV_WIDTH{1'b0}};
            level_d = ~level_q;
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = CH_IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      hp_q    <= {DIV_WIDTH{1'b0}};
      cnt_q   <= {DIV_WIDTH{1'b0}};
      rem_q   <= {DUR_WIDTH{1'b0}};
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      level_q <= level_d;
    end
  end

  assign busy  = (state_q == CH_PLAY);
  assign level = level_q;

endmodule

// File: rtl/sfx_player.sv
// Multi-channel sound-effect player: shared tick prescaler, tone channels, sigma-delta mixer.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int CLK_HZ       = 40_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DUR_WIDTH    = 12
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [NUM_CHANNELS-1:0]           TRIGGER,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] HALF_PERIOD,
  input  logic [NUM_CHANNELS*DUR_WIDTH-1:0] DURATION,
  input  logic                              MUTE,
  output logic [NUM_CHANNELS-1:0]           BUSY,
  output logic                              AUDIO
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = clog2(TICK_DIV);
  localparam int SW       = clog2(NUM_CHANNELS + 1);
  localparam int AW       = SW + 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick_s;
  logic [NUM_CHANNELS-1:0] level_s;
  logic [SW-1:0]           sum_s;
  logic [AW-1:0]           total_s;
  logic [AW-1:0]           acc_q, acc_d;
  logic                    audio_q, audio_d;

  // Free-running prescaler; never restarted by triggers so all channels share one tick phase.
  always_comb begin
    tick_s = (presc_q == PW'(TICK_DIV - 1));
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      sfx_channel #(
        .DIV_WIDTH (DIV_WIDTH),
        .DUR_WIDTH (DUR_WIDTH)
      ) u_ch (
        .clk         (CLK),
        .rst         (RESET),
        .tick        (tick_s),
        .trigger     (TRIGGER[gi]),
        .half_period (HALF_PERIOD[gi*DIV_WIDTH +: DIV_WIDTH]),
        .duration    (DURATION[gi*DUR_WIDTH +: DUR_WIDTH]),
        .busy        (BUSY[gi]),
        .level       (level_s[gi])
      );
    end
  endgenerate

  // First-order sigma-delta: density of ones equals active-high channels / NUM_CHANNELS; mute freezes acc.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum_s = sum_s + SW'(level_s[i]);
    end
    total_s = acc_q + AW'(sum_s);
    if (MUTE) begin
      audio_d = 1'b0;
      acc_d   = acc_q;
    end else if (total_s >= AW'(NUM_CHANNELS)) begin
      audio_d = 1'b1;
      acc_d   = total_s - AW'(NUM_CHANNELS);
    end else begin
      audio_d = 1'b0;
      acc_d   = total_s;
    end
  end

  // Prescaler, accumulator and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q <= {PW{1'b0}};
      acc_q   <= {AW{1'b0}};
      audio_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      acc_q   <= acc_d;
      audio_q <= audio_d;
    end
  end

  assign AUDIO = audio_q;

endmodule
